uart_byte_seg_disp: RTL and testbench
=====================================

# uart_byte_seg_disp

Display stage fed directly by the UART receiver's `uart_done`/`uart_data` pair. It keeps a three-byte history of received bytes and multiplexes it as six hex digits onto the board's six-digit common-anode 7-segment display (`seg_sel`/`seg_led`). It also provides a stretched activity indicator on the rightmost decimal point and a wrap-around received-byte counter for debug.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz
- `SCAN_HZ`, 1000, digit-step rate in Hz; `SCAN_DIV = CLK_FREQ/SCAN_HZ` must be ≥ 2
- `ACT_MS`, 50, activity-dp stretch in ms; `ACT_CYC = (CLK_FREQ/1000)*ACT_MS` must be ≥ 1
- `clk`  in  1  system clock, rising edge
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `byte_valid`  in  1  one-cycle strobe; connects to `uart_done`
- `byte_data`  in  8  received byte, valid while `byte_valid` = 1
- `clr`  in  1  synchronous clear of history, fill level, activity and counter
- `seg_sel`  out  6  digit enables, active-low; bit 0 = rightmost digit
- `seg_led`  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}
- `rx_count`  out  16  bytes accepted since reset/clr, wraps 0xFFFF→0x0000

## Operation
- History `hist[23:0]`: on `byte_valid`, `hist <= {hist[15:0], byte_data}`. Digit i shows nibble `hist[4i+3:4i]`, so digits 1:0 = newest byte and digits 5:4 = oldest byte.
- Fill counter `fill` (0..3), saturating at 3, increments per byte. Digits 2j and 2j+1 show blank (`seg_led` 0xFF) while `fill` ≤ j.
- Hex encoding for digits 0–F, dp off: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Activity counter `act`: on `byte_valid` it loads `ACT_CYC` (retriggerable); otherwise it decrements to 0. While `act` ≠ 0 and digit 0 is selected, `seg_led[7]` = 0. The dp is off on all other digits.
- `rx_count` increments by 1 per `byte_valid`, modulo 2^16.
- Scan:
  - Divider `div` counts 0..SCAN_DIV-1.
  - At `div` = SCAN_DIV-1, `div` goes to 0 and digit index `idx` advances 0→1→…→5→0.
  - Only 6 index values are legal. Any other value returns to 0.
- `clr` = 1: `hist`, `fill`, `act`, `rx_count`, `div`, `idx` are all cleared. If `byte_valid` = 1 in the same cycle, the byte is applied after the clear: `hist` = {16'h0, byte_data}, `fill` = 1, `act` = ACT_CYC, `rx_count` = 1.

## Timing
- Reset values (async): `seg_sel` = 6'h3F (all off), `seg_led` = 8'hFF, `rx_count` = 0. Internal: `hist` = 0, `fill` = 0, `act` = 0, `div` = 0, `idx` = 0.
- `seg_sel` and `seg_led` are registered. They reflect `idx`/`hist`/`fill`/`act` as of the previous cycle, so there is 1 cycle of latency.
  - First edge after reset release: `seg_sel` = 6'h3E, `seg_led` = 0xFF.
- Byte sampled at edge k:
  - `rx_count` updates at edge k.
  - `seg_led` shows the new byte at edge k+1 if digit 0 or 1 is selected.
- Each digit is held for exactly SCAN_DIV cycles. The `seg_sel` sequence is 3E, 3D, 3B, 37, 2F, 1F, then repeats. Exactly one bit is low at any time after the first post-reset edge.
- `byte_valid` on consecutive cycles: each cycle is accepted. No back-pressure exists.
- Reset asserted mid-scan forces the reset values immediately. Scanning restarts at digit 0.

## Test plan
Bench parameters for all scenarios: CLK_FREQ = 1000, SCAN_HZ = 250 (SCAN_DIV = 4), ACT_MS = 10 (ACT_CYC = 10).

- **Reset and blank scan:** hold reset, then release with no input.
  - During reset: `seg_sel` = 3F, `seg_led` = FF, `rx_count` = 0.
  - After release: `seg_sel` steps 3E,3D,3B,37,2F,1F, 4 cycles each, then wraps to 3E; `seg_led` stays FF throughout.
- **Single byte and activity:** strobe 0x5A once.
  - Digit 0 shows 0x08 (A, dp lit); digit 1 shows 0x92; digits 2–5 show FF; `rx_count` = 1.
  - From 10 cycles after the strobe, digit 0 shows 0x88.
- **History roll:** strobe 0x12, 0x34, 0x56, 0x78 back-to-back.
  - Digits 5..0 show 3,4,5,6,7,8 (B0,99,92,82,F8,80; digit 0 shows 0x00 while dp is active).
  - `rx_count` = 4.
- **Clear collision:** after the history-roll scenario, assert `clr` and a `byte_valid` of 0xC3 in the same cycle.
  - Digit 0 shows 3 (dp active, 0x30); digit 1 shows C6; digits 2–5 show FF.
  - `rx_count` = 1; scan restarts at digit 0.
- **Counter wrap:** issue 65536 strobes. `rx_count` reads 0xFFFF after the 65535th and 0x0000 after the 65536th; `fill` stays 3.
- **Mid-scan reset:** assert `sys_rst_n` low asynchronously while digit 3 is active.
  - `seg_sel` = 3F and `seg_led` = FF without waiting for a clock edge.
  - After release, the scan resumes at 3E.

Source files
------------

// File: rtl/uart_byte_seg_disp.sv
// ---------------------------------------------------------------------------
// uart_byte_seg_disp
//
// Display stage for the UART receiver. Keeps the last three received bytes
// and scans them as six hex digits onto a six-digit common-anode 7-segment
// display. The rightmost decimal point is a stretched "byte received"
// indicator. A 16-bit wrap-around counter reports how many bytes were
// accepted since reset or clear.
//
// Ports:
//   clk         in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   byte_valid  in   one-cycle strobe from the receiver (uart_done)
//   byte_data   in   [7:0] received byte, valid with byte_valid
//   clr         in   synchronous clear of history, fill, activity, counter, scan
//   seg_sel     out  [5:0] digit enables, active-low, bit 0 = rightmost digit
//   seg_led     out  [7:0] segments, active-low, {dp,g,f,e,d,c,b,a}
//   rx_count    out  [15:0] bytes accepted, wraps 0xFFFF -> 0x0000
// ---------------------------------------------------------------------------
module uart_byte_seg_disp #(
  parameter int CLK_FREQ = 50000000,
  parameter int SCAN_HZ  = 1000,
  parameter int ACT_MS   = 50
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        clr,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led,
  output logic [15:0] rx_count
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int ACT_CYC  = (CLK_FREQ / 1000) * ACT_MS;
  localparam int DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int ACT_W    = $clog2(ACT_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_CYC);

  // State registers
  logic [23:0]      hist_reg, hist_next;
  logic [1:0]       fill_reg, fill_next;
  logic [ACT_W-1:0] act_reg, act_next;
  logic [15:0]      rx_cnt_reg, rx_cnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [2:0]       idx_reg, idx_next;
  logic [5:0]       seg_sel_reg, seg_sel_next;
  logic [7:0]       seg_led_reg, seg_led_next;

  // Per-digit views of the history
  logic [3:0] digit_nib [6];
  logic [5:0] digit_hot;    // one-hot of the current scan index
  logic [5:0] digit_blank;  // digit pair not yet filled

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign digit_nib[gi]   = hist_reg[4*gi +: 4];
      assign digit_hot[gi]   = (idx_reg == 3'(gi));
      // Digits 2j and 2j+1 stay dark until at least j+1 bytes have arrived.
      assign digit_blank[gi] = (fill_reg <= 2'(gi / 2));
    end
  endgenerate

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Next-state logic for history, fill, activity, counter and scan position
  always_comb begin
    hist_next   = hist_reg;
    fill_next   = fill_reg;
    act_next    = (act_reg != '0) ? act_reg - ACT_W'(1) : act_reg;
    rx_cnt_next = rx_cnt_reg;
    div_next    = div_reg + DIV_W'(1);
    idx_next    = idx_reg;

    if (div_reg == DIV_LAST) begin
      div_next = '0;
      idx_next = (idx_reg >= 3'd5) ? 3'd0 : idx_reg + 3'd1;
    end
    // An out-of-range index recovers immediately rather than waiting a step.
    if (idx_reg > 3'd5) begin
      idx_next = 3'd0;
    end

    if (clr) begin
      hist_next   = '0;
      fill_next   = '0;
      act_next    = '0;
      rx_cnt_next = '0;
      div_next    = '0;
      idx_next    = 3'd0;
    end

    // A byte arriving together with clr lands on top of the cleared state.
    if (byte_valid) begin
      hist_next   = {hist_next[15:0], byte_data};
      fill_next   = (fill_next == 2'd3) ? 2'd3 : fill_next + 2'd1;
      act_next    = ACT_LOAD;
      rx_cnt_next = rx_cnt_next + 16'd1;
    end
  end

  // Output decode from the current (pre-edge) state; registered below,
  // which gives the one-cycle display latency.
  always_comb begin
    logic [3:0] cur_nib;
    logic       cur_blank;

    cur_nib   = 4'h0;
    cur_blank = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (digit_hot[i]) begin
        cur_nib   = digit_nib[i];
        cur_blank = digit_blank[i];
      end
    end

    seg_sel_next = ~digit_hot;
    seg_led_next = cur_blank ? 8'hFF : hex_seg(cur_nib);
    if (digit_hot[0] && (act_reg != '0)) begin
      seg_led_next[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      act_reg     <= '0;
      rx_cnt_reg  <= '0;
      div_reg     <= '0;
      idx_reg     <= 3'd0;
      seg_sel_reg <= 6'h3F;
      seg_led_reg <= 8'hFF;
    end else begin
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      act_reg     <= act_next;
      rx_cnt_reg  <= rx_cnt_next;
      div_reg     <= div_next;
      idx_reg     <= idx_next;
      seg_sel_reg <= seg_sel_next;
      seg_led_reg <= seg_led_next;
    end
  end

  assign seg_sel  = seg_sel_reg;
  assign seg_led  = seg_led_reg;
  assign rx_count = rx_cnt_reg;

endmodule

// File: tb/tb_uart_byte_seg_disp.sv
module tb_uart_byte_seg_disp;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        clr;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;
  logic [15:0] rx_count;

  int compares = 0;
  int fails    = 0;

  uart_byte_seg_disp #(
    .CLK_FREQ(1000),
    .SCAN_HZ (250),
    .ACT_MS  (10)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .clr       (clr),
    .seg_sel   (seg_sel),
    .seg_led   (seg_led),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Step to the next cycle where seg_sel first becomes pat.
  task automatic wait_entry(input logic [5:0] pat, input string tag);
    int n;
    n = 0;
    while (seg_sel === pat && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (seg_sel !== pat && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (seg_sel !== pat) begin
      compares++;
      fails++;
      $error("FAIL %s timeout: observed seg_sel %h required %h", tag, seg_sel, pat);
    end
  endtask

  task automatic check_digit(input int d, input logic [7:0] exp, input string tag);
    logic [5:0] pat;
    pat = ~(6'd1 << d);
    wait_entry(pat, tag);
    check(tag, {8'h00, seg_led}, {8'h00, exp});
  endtask

  task automatic do_reset();
    sys_rst_n  = 1'b0;
    byte_valid = 1'b0;
    clr        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  logic [5:0] pats [6];

  initial begin
    pats = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    sys_rst_n  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    clr        = 1'b0;

    // Reset and blank scan
    repeat (3) @(negedge clk);
    check("rst_sel", {10'h0, seg_sel}, 16'h003F);
    check("rst_led", {8'h0, seg_led}, 16'h00FF);
    check("rst_cnt", rx_count, 16'h0000);
    sys_rst_n = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      check($sformatf("scan_sel_%0d", n), {10'h0, seg_sel}, {10'h0, pats[((n - 1) / 4) % 6]});
      check($sformatf("scan_led_%0d", n), {8'h0, seg_led}, 16'h00FF);
    end

    // Single byte 0x5A, strobed one cycle into a digit-0 window
    wait_entry(6'h3E, "t2_align");
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    @(negedge clk);
    byte_valid = 1'b0;
    check("t2_cnt", rx_count, 16'h0001);
    @(negedge clk);
    check("t2_sel0", {10'h0, seg_sel}, 16'h003E);
    check("t2_d0_dp", {8'h0, seg_led}, 16'h0008);
    check_digit(1, 8'h92, "t2_d1");
    check_digit(2, 8'hFF, "t2_d2");
    check_digit(3, 8'hFF, "t2_d3");
    check_digit(4, 8'hFF, "t2_d4");
    check_digit(5, 8'hFF, "t2_d5");
    check_digit(0, 8'h88, "t2_d0_nodp");

    // History roll: four bytes ending just as digit 0 comes up
    do_reset();
    wait_entry(6'h1F, "t3_align");
    byte_valid = 1'b1;
    byte_data  = 8'h12; @(negedge clk);
    byte_data  = 8'h34; @(negedge clk);
    byte_data  = 8'h56; @(negedge clk);
    byte_data  = 8'h78; @(negedge clk);
    byte_valid = 1'b0;
    check("t3_cnt", rx_count, 16'h0004);
    @(negedge clk);
    check("t3_sel0", {10'h0, seg_sel}, 16'h003E);
    check("t3_d0_dp", {8'h0, seg_led}, 16'h0000);
    check_digit(1, 8'hF8, "t3_d1");
    check_digit(2, 8'h82, "t3_d2");
    check_digit(3, 8'h92, "t3_d3");
    check_digit(4, 8'h99, "t3_d4");
    check_digit(5, 8'hB0, "t3_d5");

    // Clear colliding with a byte, issued while digit 3 is on
    wait_entry(6'h37, "t4_align");
    clr        = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hC3;
    @(negedge clk);
    clr        = 1'b0;
    byte_valid = 1'b0;
    check("t4_cnt", rx_count, 16'h0001);
    @(negedge clk);
    check("t4_sel0", {10'h0, seg_sel}, 16'h003E);
    check("t4_d0_dp", {8'h0, seg_led}, 16'h0030);
    repeat (3) @(negedge clk);
    check("t4_sel0_hold", {10'h0, seg_sel}, 16'h003E);
    @(negedge clk);
    check("t4_sel1", {10'h0, seg_sel}, 16'h003D);
    check("t4_d1", {8'h0, seg_led}, 16'h00C6);
    check_digit(2, 8'hFF, "t4_d2");
    check_digit(3, 8'hFF, "t4_d3");
    check_digit(4, 8'hFF, "t4_d4");
    check_digit(5, 8'hFF, "t4_d5");

    // Counter wrap over 65536 back-to-back strobes
    do_reset();
    byte_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      byte_data = 8'(i);
      @(negedge clk);
    end
    check("t5_cnt_ffff", rx_count, 16'hFFFF);
    byte_data = 8'hFF;
    @(negedge clk);
    byte_valid = 1'b0;
    check("t5_cnt_wrap", rx_count, 16'h0000);
    check_digit(5, 8'h8E, "t5_d5");
    check_digit(4, 8'hA1, "t5_d4");

    // Asynchronous reset while digit 3 is active
    wait_entry(6'h37, "t6_align");
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("t6_sel", {10'h0, seg_sel}, 16'h003F);
    check("t6_led", {8'h0, seg_led}, 16'h00FF);
    check("t6_cnt", rx_count, 16'h0000);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    check("t6_resume", {10'h0, seg_sel}, 16'h003E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
